// File: rtl/idm_arbiter_if.sv
// Shared instruction/data memory port bundle: fetch and data requesters on one
// side, the arbiter and the single-ported idm on the other.
interface idm_arbiter_if;
  logic        f_req;
  logic [7:0]  f_adr;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_adr;
  logic [7:0]  d_wd;
  logic        f_gnt;
  logic        d_gnt;
  logic        f_valid;
  logic        d_valid;
  logic [13:0] f_rdata;
  logic [13:0] d_rdata;
  logic        memWrite;
  logic [7:0]  adr;
  logic [7:0]  WD;
  logic [13:0] RD;
  logic        busy;
  logic [7:0]  fetch_cnt;

  modport slave (
    input  f_req, f_adr, d_req, d_we, d_adr, d_wd, RD,
    output f_gnt, d_gnt, f_valid, d_valid, f_rdata, d_rdata,
           memWrite, adr, WD, busy, fetch_cnt
  );

  modport master (
    output f_req, f_adr, d_req, d_we, d_adr, d_wd, RD,
    input  f_gnt, d_gnt, f_valid, d_valid, f_rdata, d_rdata,
           memWrite, adr, WD, busy, fetch_cnt
  );
endinterface

// File: rtl/idm_arbiter.sv
// Round-robin arbiter giving instruction fetch and data accesses turns on one
// shared idm port; one access per two cycles, read data captured on exit.
//
// state | meaning
// IDLE  | sample requests, latch winner's operands
// ACC_F | fetch owns the idm for one cycle (f_gnt high)
// ACC_D | data owns the idm for one cycle (d_gnt high, write if latched we)
module idm_arbiter (
  input  logic         clk,
  input  logic         reset,
  idm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_F = 2'd1,
    ACC_D = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  adr_q, adr_d;
  logic [7:0]  wd_q, wd_d;
  logic        we_q, we_d;
  logic        last_data_q, last_data_d;
  logic        f_valid_q, f_valid_d;
  logic        d_valid_q, d_valid_d;
  logic [13:0] f_rdata_q, f_rdata_d;
  logic [13:0] d_rdata_q, d_rdata_d;
  logic [7:0]  fetch_cnt_q, fetch_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      adr_q       <= 8'h00;
      wd_q        <= 8'h00;
      we_q        <= 1'b0;
      last_data_q <= 1'b1;
      f_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      f_rdata_q   <= 14'h0000;
      d_rdata_q   <= 14'h0000;
      fetch_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      wd_q        <= wd_d;
      we_q        <= we_d;
      last_data_q <= last_data_d;
      f_valid_q   <= f_valid_d;
      d_valid_q   <= d_valid_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    wd_d        = wd_q;
    we_d        = we_q;
    last_data_d = last_data_q;
    f_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      IDLE: begin
        // On a tie, fetch wins only if data owned the port last.
        if (bus.f_req && (!bus.d_req || last_data_q)) begin
          state_d     = ACC_F;
          adr_d       = bus.f_adr;
          we_d        = 1'b0;
          last_data_d = 1'b0;
        end else if (bus.d_req) begin
          state_d     = ACC_D;
          adr_d       = bus.d_adr;
          we_d        = bus.d_we;
          wd_d        = bus.d_wd;
          last_data_d = 1'b1;
        end
      end
      ACC_F: begin
        state_d     = IDLE;
        f_valid_d   = 1'b1;
        f_rdata_d   = bus.RD;
        fetch_cnt_d = fetch_cnt_q + 8'd1;
      end
      ACC_D: begin
        // RD is sampled on the same edge the idm writes, so writes return old data.
        state_d   = IDLE;
        d_valid_d = 1'b1;
        d_rdata_d = bus.RD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.f_gnt     = (state_q == ACC_F);
  assign bus.d_gnt     = (state_q == ACC_D);
  assign bus.memWrite  = (state_q == ACC_D) && we_q;
  assign bus.adr       = adr_q;
  assign bus.WD        = wd_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.f_valid   = f_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_idm_arbiter.sv
// Directed bench for idm_arbiter with a behavioural 256x14 idm on the shared port.
module tb_idm_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [13:0] idm [256];
  logic        pl_en;
  logic [7:0]  pl_adr;
  logic [13:0] pl_dat;

  idm_arbiter_if bus ();

  idm_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.RD = idm[bus.adr];

  always @(posedge clk) begin
    if (pl_en) idm[pl_adr] <= pl_dat;
    else if (bus.memWrite) idm[bus.adr] <= {6'b0, bus.WD};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [13:0] d);
    pl_adr = a;
    pl_dat = d;
    pl_en  = 1'b1;
    tick();
    pl_en  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.f_gnt, bus.d_gnt, bus.f_valid, bus.d_valid, bus.memWrite, bus.busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000", {bus.f_gnt, bus.d_gnt, bus.f_valid, bus.d_valid, bus.memWrite, bus.busy});
    end
    n_checks++;
    if (bus.fetch_cnt !== 8'h00) begin
      n_fail++; $display("FAIL reset_fetch_cnt: got %h expected 00", bus.fetch_cnt);
    end
    n_checks++;
    if ({bus.f_rdata, bus.d_rdata} !== 28'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.f_rdata, bus.d_rdata);
    end
    n_checks++;
    if ({bus.adr, bus.WD} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_adr_wd: got %h/%h expected 00/00", bus.adr, bus.WD);
    end
    preload(8'h10, 14'h1ABC);
    preload(8'h20, 14'h3FFF);
    preload(8'h30, 14'h0123);
    preload(8'h55, 14'h2222);
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.f_gnt, bus.d_gnt, bus.busy} !== 3'b000) begin
        n_fail++; $display("FAIL idle_no_grant: got %b expected 000", {bus.f_gnt, bus.d_gnt, bus.busy});
      end
    end
  endtask

  task automatic test_single_fetch();
    bus.f_req = 1'b1;
    bus.f_adr = 8'h10;
    tick();
    n_checks++;
    if ({bus.f_gnt, bus.d_gnt, bus.busy, bus.memWrite} !== 4'b1010) begin
      n_fail++; $display("FAIL fetch_gnt: got %b expected 1010", {bus.f_gnt, bus.d_gnt, bus.busy, bus.memWrite});
    end
    n_checks++;
    if (bus.adr !== 8'h10) begin
      n_fail++; $display("FAIL fetch_adr: got %h expected 10", bus.adr);
    end
    bus.f_req = 1'b0;
    tick();
    n_checks++;
    if ({bus.f_valid, bus.f_gnt, bus.busy} !== 3'b100) begin
      n_fail++; $display("FAIL fetch_valid: got %b expected 100", {bus.f_valid, bus.f_gnt, bus.busy});
    end
    n_checks++;
    if (bus.f_rdata !== 14'h1ABC) begin
      n_fail++; $display("FAIL fetch_rdata: got %h expected 1abc", bus.f_rdata);
    end
    n_checks++;
    if (bus.fetch_cnt !== 8'h01) begin
      n_fail++; $display("FAIL fetch_cnt: got %h expected 01", bus.fetch_cnt);
    end
    tick();
    n_checks++;
    if ({bus.f_valid, bus.f_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_once: got %b expected 00", {bus.f_valid, bus.f_gnt});
    end
  endtask

  task automatic test_write_read();
    bus.d_req = 1'b1;
    bus.d_we  = 1'b1;
    bus.d_adr = 8'h20;
    bus.d_wd  = 8'h5A;
    tick();
    n_checks++;
    if ({bus.d_gnt, bus.f_gnt, bus.memWrite} !== 3'b101) begin
      n_fail++; $display("FAIL write_gnt: got %b expected 101", {bus.d_gnt, bus.f_gnt, bus.memWrite});
    end
    n_checks++;
    if ({bus.adr, bus.WD} !== 16'h205A) begin
      n_fail++; $display("FAIL write_bus: got %h/%h expected 20/5a", bus.adr, bus.WD);
    end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    n_checks++;
    if ({bus.d_valid, bus.memWrite, bus.d_gnt} !== 3'b100) begin
      n_fail++; $display("FAIL write_valid: got %b expected 100", {bus.d_valid, bus.memWrite, bus.d_gnt});
    end
    n_checks++;
    if (bus.d_rdata !== 14'h3FFF) begin
      n_fail++; $display("FAIL write_prewrite_rdata: got %h expected 3fff", bus.d_rdata);
    end
    n_checks++;
    if (bus.f_rdata !== 14'h1ABC) begin
      n_fail++; $display("FAIL write_f_rdata_hold: got %h expected 1abc", bus.f_rdata);
    end
    n_checks++;
    if (idm[8'h20] !== 14'h005A) begin
      n_fail++; $display("FAIL write_mem: got %h expected 005a", idm[8'h20]);
    end
    n_checks++;
    if ({bus.adr, bus.WD} !== 16'h205A) begin
      n_fail++; $display("FAIL idle_hold_bus: got %h/%h expected 20/5a", bus.adr, bus.WD);
    end
    bus.d_req = 1'b1;
    bus.d_adr = 8'h20;
    bus.d_wd  = 8'h00;
    tick();
    n_checks++;
    if ({bus.d_gnt, bus.memWrite} !== 2'b10) begin
      n_fail++; $display("FAIL read_gnt: got %b expected 10", {bus.d_gnt, bus.memWrite});
    end
    bus.d_req = 1'b0;
    tick();
    n_checks++;
    if ({bus.d_valid, bus.d_rdata} !== {1'b1, 14'h005A}) begin
      n_fail++; $display("FAIL read_rdata: got %b/%h expected 1/005a", bus.d_valid, bus.d_rdata);
    end
  endtask

  task automatic test_contention();
    #4 reset = 1'b1;
    bus.f_req = 1'b1;
    bus.f_adr = 8'h40;
    bus.d_req = 1'b1;
    bus.d_we  = 1'b1;
    bus.d_adr = 8'h41;
    bus.d_wd  = 8'h77;
    tick();
    #4 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({bus.f_gnt, bus.d_gnt, bus.memWrite} !== ((i % 2 == 0) ? 3'b100 : 3'b011)) begin
        n_fail++; $display("FAIL contention_grant%0d: got %b expected %b", i, {bus.f_gnt, bus.d_gnt, bus.memWrite}, (i % 2 == 0) ? 3'b100 : 3'b011);
      end
      tick();
      n_checks++;
      if ({bus.f_gnt, bus.d_gnt, bus.busy} !== 3'b000) begin
        n_fail++; $display("FAIL contention_idle%0d: got %b expected 000", i, {bus.f_gnt, bus.d_gnt, bus.busy});
      end
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    n_checks++;
    if (bus.fetch_cnt !== 8'h02) begin
      n_fail++; $display("FAIL contention_fetch_cnt: got %h expected 02", bus.fetch_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    bus.d_req = 1'b1;
    bus.d_we  = 1'b1;
    bus.d_adr = 8'h30;
    bus.d_wd  = 8'hAA;
    tick();
    n_checks++;
    if (bus.memWrite !== 1'b1) begin
      n_fail++; $display("FAIL abort_write_start: got %b expected 1", bus.memWrite);
    end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    #4 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.memWrite, bus.d_gnt, bus.busy, bus.adr, bus.WD} !== 19'h0) begin
      n_fail++; $display("FAIL abort_async: got %b/%b/%b/%h/%h expected all zero", bus.memWrite, bus.d_gnt, bus.busy, bus.adr, bus.WD);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.d_valid !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_valid: got %b expected 0", bus.d_valid);
      end
    end
    n_checks++;
    if (idm[8'h30] !== 14'h0123) begin
      n_fail++; $display("FAIL abort_mem: got %h expected 0123", idm[8'h30]);
    end
    #4 reset = 1'b0;
    tick();
  endtask

  task automatic test_counter_wrap();
    logic [7:0] exp_cnt;
    exp_cnt = 8'h00;
    bus.f_req = 1'b1;
    bus.f_adr = 8'h55;
    for (int i = 0; i < 256; i++) begin
      tick();
      n_checks++;
      if ({bus.busy, bus.f_gnt} !== 2'b11) begin
        n_fail++; $display("FAIL wrap_busy_acc%0d: got %b expected 11", i, {bus.busy, bus.f_gnt});
      end
      if (i == 255) bus.f_req = 1'b0;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      n_checks++;
      if ({bus.busy, bus.f_valid, bus.fetch_cnt} !== {2'b01, exp_cnt}) begin
        n_fail++; $display("FAIL wrap_idle%0d: got %b/%b/%h expected 0/1/%h", i, bus.busy, bus.f_valid, bus.fetch_cnt, exp_cnt);
      end
    end
    n_checks++;
    if (bus.fetch_cnt !== 8'h00) begin
      n_fail++; $display("FAIL wrap_final: got %h expected 00", bus.fetch_cnt);
    end
    n_checks++;
    if (bus.f_rdata !== 14'h2222) begin
      n_fail++; $display("FAIL wrap_rdata: got %h expected 2222", bus.f_rdata);
    end
    tick();
    n_checks++;
    if ({bus.busy, bus.f_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL wrap_stop: got %b expected 00", {bus.busy, bus.f_gnt});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pl_en    = 1'b0;
    pl_adr   = 8'h00;
    pl_dat   = 14'h0000;
    bus.f_req = 1'b0;
    bus.f_adr = 8'h00;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    bus.d_adr = 8'h00;
    bus.d_wd  = 8'h00;
    test_reset();
    test_single_fetch();
    test_write_read();
    test_contention();
    test_reset_mid_write();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
